// File: rtl/cla_seq_ctrl.sv
// Sequential carry-lookahead adder/subtractor: one 4-bit CLA slice reused
// LSB-first, one slice per clock, with a valid/ready request and result handshake.

module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       c3
);
  logic [3:0] g, p;
  logic [4:0] c;

  always_comb begin
    g    = a & b;
    p    = a | b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    // p = a|b is only valid for carries; the sum bit needs the true half-sum
    s    = a ^ b ^ c[3:0];
    cout = c[4];
    c3   = c[3];
  end
endmodule

module cla_seq_ctrl #(
  parameter int SLICES = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*SLICES-1:0] a,
  input  logic [4*SLICES-1:0] b,
  input  logic                ci,
  input  logic                op_sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*SLICES-1:0] sum,
  output logic                co,
  output logic                ov,
  output logic                busy
);
  localparam int W  = 4 * SLICES;
  localparam int CW = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [CW-1:0] LAST = CW'(SLICES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic          cy_q, cy_d, co_q, co_d, ov_q, ov_d;

  logic [3:0]    sl_a, sl_b, sl_s;
  logic          sl_cout, sl_c3;

  // Operand slice selected by the counter
  always_comb begin
    sl_a = '0;
    sl_b = '0;
    for (int i = 0; i < SLICES; i++) begin
      if (cnt_q == CW'(i)) begin
        sl_a = a_q[4*i +: 4];
        sl_b = b_q[4*i +: 4];
      end
    end
  end

  cla4_slice u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (cy_q),
    .s    (sl_s),
    .cout (sl_cout),
    .c3   (sl_c3)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cy_d    = cy_q;
    co_d    = co_q;
    ov_d    = ov_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = op_sub ? ~b : b;
          cy_d    = op_sub ? 1'b1 : ci;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < SLICES; i++) begin
          if (cnt_q == CW'(i)) sum_d[4*i +: 4] = sl_s;
        end
        cy_d = sl_cout;
        if (cnt_q == LAST) begin
          // carry into bit W-1 is the slice's internal carry into its bit 3
          co_d    = sl_cout;
          ov_d    = sl_c3 ^ sl_cout;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cy_q    <= 1'b0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cy_q    <= cy_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign sum       = sum_q;
  assign co        = co_q;
  assign ov        = ov_q;
endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Directed-vector bench for cla_seq_ctrl with SLICES=8 (32-bit operands).

module tb_cla_seq_ctrl;
  localparam int SLICES = 8;
  localparam int W      = 4 * SLICES;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, ci, op_sub;
  logic         out_valid, out_ready, co, ov, busy;
  logic [W-1:0] a, b, sum;
  int           nvec = 0;
  int           nerr = 0;
  int           cyc  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cla_seq_ctrl #(.SLICES(SLICES)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .co        (co),
    .ov        (ov),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // lat counts rising edges from the acceptance edge (inclusive) to the edge
  // after which out_valid is visible: SLICES+1.
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic civ, input logic subv,
                        input logic [W-1:0] es, input logic eco, input logic eov);
    int lat;
    chk({tag, ".rdy"}, 64'(in_ready), 64'd1);
    a = av; b = bv; ci = civ; op_sub = subv; in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      step;
      lat++;
    end
    chk({tag, ".lat"}, 64'(lat), 64'd9);
    chk({tag, ".sum"}, 64'(sum), 64'(es));
    chk({tag, ".co_ov"}, 64'({co, ov}), 64'({eco, eov}));
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    chk({tag, ".idle"}, 64'({out_valid, in_ready, busy}), 64'b010);
  endtask

  initial begin
    int t1, t2, n;
    logic [W-1:0] r1, r2;
    logic         got1, got2;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; ci = 1'b0; op_sub = 1'b0;
    step; step;
    reset = 1'b0;
    chk("rst.hs", 64'({in_ready, out_valid, busy}), 64'b100);
    chk("rst.res", 64'({sum, co, ov}), 64'd0);

    run_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_op("sub_neg",  32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op("sub_ci1",  32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op("add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_op("add_ci",   32'h0000_000F, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0010, 1'b0, 1'b0);
    run_op("sub_ovf",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

    // Hold in DONE: 0x90000000+0x90000000 -> 0x20000000, co=1, ov=1
    a = 32'h9000_0000; b = 32'h9000_0000; ci = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      step;
      n++;
    end
    chk("hold.vld", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      a = $urandom; b = $urandom; op_sub = i[0];
      step;
      chk("hold.hs", 64'({out_valid, in_ready, busy}), 64'b101);
      chk("hold.res", 64'({sum, co, ov}), {30'd0, 32'h2000_0000, 2'b11});
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    chk("hold.rel", 64'({out_valid, in_ready}), 64'b01);
    chk("hold.keep", 64'({sum, co, ov}), {30'd0, 32'h2000_0000, 2'b11});

    // Reset in the middle of RUN, with in_valid also high at the reset edge
    a = 32'hDEAD_BEEF; b = 32'h0123_4567; ci = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    step; step; step;
    reset = 1'b1; in_valid = 1'b1;
    step;
    reset = 1'b0; in_valid = 1'b0;
    chk("mrst.hs", 64'({out_valid, busy, in_ready}), 64'b001);
    chk("mrst.sum", 64'({sum, co, ov}), 64'd0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      step;
      if (out_valid) n++;
    end
    chk("mrst.nores", 64'(n), 64'd0);
    run_op("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

    // Back-to-back with out_ready held high; op2 inputs appear during op1's RUN
    out_ready = 1'b1;
    a = 32'h0F0F_0F0F; b = 32'h0101_0101; ci = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    t1 = cyc;
    #1;
    a = 32'h0000_0000; b = 32'h0000_0001; op_sub = 1'b1;
    got1 = 1'b0; got2 = 1'b0; r1 = '0; r2 = '0; t2 = -1;
    n = 0;
    while (!in_ready && n < 40) begin
      if (out_valid) begin got1 = 1'b1; r1 = sum; end
      step;
      n++;
    end
    @(posedge clk);
    t2 = cyc;
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      step;
      n++;
    end
    if (out_valid) begin got2 = 1'b1; r2 = sum; end
    chk("b2b.interval", 64'(t2 - t1), 64'd10);
    chk("b2b.r1", 64'({got1, r1}), {31'd0, 1'b1, 32'h1010_1010});
    chk("b2b.r2", 64'({got2, r2, co, ov}), {29'd0, 1'b1, 32'hFFFF_FFFF, 2'b00});
    step;
    out_ready = 1'b0;
    chk("b2b.end", 64'({out_valid, in_ready}), 64'b01);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/cla_seq_ctrl.md
CLA_SEQ_CTRL -- requirements
Module: cla_seq_ctrl

Interface
REQ-001 Parameter: SLICES, default 8, number of 4-bit carry-lookahead slices per operation; operand width W = 4*SLICES.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  requester presents an operation.
REQ-005 in_ready  output  1  controller can accept an operation (high only in IDLE).
REQ-006 a  input  W  operand A.
REQ-007 b  input  W  operand B.
REQ-008 ci  input  1  carry-in for add; ignored for subtract.
REQ-009 op_sub  input  1  0 = A+B+ci, 1 = A-B (A + ~B + 1).
REQ-010 out_valid  output  1  result registers hold a completed operation.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 sum  output  W  result.
REQ-013 co  output  1  carry out of MSB (for subtract: 1 = no borrow).
REQ-014 ov  output  1  signed overflow = carry into MSB XOR carry out of MSB.
REQ-015 busy  output  1  high in RUN or DONE.

Function
REQ-016 The block SHALL reuse one 4-bit CLA slice (generate g=a&b, propagate p=a|b, lookahead carry) iteratively, one slice per clock, LSB slice first.
REQ-017 FSM states: IDLE, RUN, DONE; encoding is free.
REQ-018 IDLE: in_ready=1; on in_valid=1, latch a, (op_sub ? ~b : b), carry register <= (op_sub ? 1 : ci), slice counter <= 0, clear sum, go RUN.
REQ-019 RUN: each cycle compute slice cnt from latched operands and carry register; write sum[4*cnt+3:4*cnt], carry register <= slice carry-out, cnt <= cnt+1.
REQ-020 RUN: in the cycle cnt = SLICES-1, co <= slice carry-out, ov <= carry into bit W-1 XOR slice carry-out, go DONE.
REQ-021 Latency: operation accepted at edge T; RUN occupies edges T+1..T+SLICES; out_valid=1 from edge T+SLICES (visible in cycle following it), i.e. SLICES+1 cycles after acceptance.
REQ-022 DONE: out_valid=1; sum, co, ov SHALL remain stable until out_ready=1 sampled high.
REQ-023 DONE with out_ready=1: go IDLE; out_valid drops next cycle; sum/co/ov retain last values.
REQ-024 in_ready SHALL be 0 in RUN and DONE; in_valid there is ignored and does not corrupt in-flight state.
REQ-025 No overlap: a new operation is never accepted in the same cycle as a result handshake; minimum issue interval is SLICES+2 cycles.
REQ-026 Operand inputs SHALL be sampled only at acceptance; changes during RUN/DONE have no effect.
REQ-027 Slice counter SHALL be ceil(log2(SLICES)) bits wide, clamped to ≥1 bit, and never wraps within an operation.
REQ-028 out_valid, in_ready, busy SHALL be registered-state decodes with no combinational path from in_valid or out_ready.

Reset
REQ-029 reset=1 at any edge SHALL force IDLE, cnt=0, carry register=0, sum=0, co=0, ov=0, out_valid=0, busy=0; in_ready=1 in the following cycle.
REQ-030 reset mid-RUN or mid-DONE SHALL abandon the operation with no result delivered; reset overrides simultaneous in_valid.

Verification
REQ-031 Add 0xFFFFFFFF + 0x00000001, ci=0 -> sum=0x00000000, co=1, ov=0, out_valid exactly 9 cycles after acceptance.
REQ-032 Sub 0x00000005 - 0x00000007 -> sum=0xFFFFFFFE, co=0, ov=0; repeat with ci=1 -> identical result.
REQ-033 Add 0x7FFFFFFF + 0x00000001, ci=0 -> sum=0x80000000, co=0, ov=1; add 0x0000000F + 0, ci=1 -> sum=0x00000010, co=0, ov=0.
REQ-034 Hold out_ready=0 five cycles in DONE while toggling in_valid and a/b -> out_valid, sum, co, ov stable, in_ready=0; then out_ready=1 -> IDLE next cycle.
REQ-035 Assert reset at RUN cycle 4 -> next cycle out_valid=0, sum=0, busy=0, in_ready=1; subsequent 0x12345678 + 0x11111111 -> sum=0x23456789, co=0.
REQ-036 Back-to-back: two operations issued at earliest in_ready -> both results correct, issue interval = 10 cycles with out_ready held 1.
